// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point multiplier arbiter: widths, common
// IEEE-754 constants and the arbiter state encoding.
package fp_pkg;

    localparam int unsigned DATA_W = 32;

    // Single-precision constants used by the function datapaths sharing the multiplier.
    localparam logic [31:0] FP_HALF   = 32'h3F00_0000;
    localparam logic [31:0] FP_ONE    = 32'h3F80_0000;
    localparam logic [31:0] FP_128    = 32'h4300_0000;
    localparam logic [31:0] FP_INV128 = 32'h3C00_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    // Round-robin successor of a grant index, wrapping at n requesters.
    function automatic logic [2:0] rr_next(input logic [2:0] id, input int unsigned n);
        if (32'(id) + 32'd1 >= n) begin
            return 3'd0;
        end
        return id + 3'd1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after the pointer,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic               valid_o,
    output logic [2:0]         winner_o
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [IdxW-1:0] idx;

    always_comb begin
        valid_o  = 1'b0;
        winner_o = 3'd0;
        idx      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IdxW'((32'(ptr_i) + k) % NUM_REQ);
            // The first hit in search order wins; later hits are ignored.
            if (!valid_o && req_i[idx]) begin
                valid_o  = 1'b1;
                winner_o = 3'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_mult_arbiter.sv
// Shares one handshake-driven floating-point multiplier among NUM_REQ requesters
// with round-robin arbitration, operand latching and a watchdog abort.
module fp_mult_arbiter
    import fp_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = fp_pkg::DATA_W,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_dataa,
    input  logic [NUM_REQ*DATA_W-1:0] req_datab,
    output logic [NUM_REQ-1:0]        resp_done,
    output logic [NUM_REQ-1:0]        resp_err,
    output logic [DATA_W-1:0]         resp_result,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic [DATA_W-1:0]         mult_dataa,
    output logic [DATA_W-1:0]         mult_datab,
    output logic                      mult_enable,
    input  logic [DATA_W-1:0]         mult_result,
    input  logic                      mult_done
);

    localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [NUM_REQ-1:0] OneHot0 = NUM_REQ'(1);

    state_e              state_q, state_d;
    logic [2:0]          ptr_q, ptr_d;
    logic [2:0]          grant_q, grant_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [DATA_W-1:0]   b_q, b_d;
    logic                en_q, en_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic [DATA_W-1:0]   result_q, result_d;

    logic                pick_valid;
    logic [2:0]          pick_id;
    logic [DATA_W-1:0]   pick_a, pick_b;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .valid_o  (pick_valid),
        .winner_o (pick_id)
    );

    // Operand mux over the packed request buses.
    always_comb begin
        pick_a = '0;
        pick_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_id == 3'(i)) begin
                pick_a = req_dataa[i*DATA_W +: DATA_W];
                pick_b = req_datab[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        grant_d  = grant_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        en_d     = en_q;
        result_d = result_q;
        done_d   = '0;
        err_d    = '0;

        unique case (state_q)
            StIdle: begin
                // mult_done is deliberately not looked at here: any level seen now is stale.
                if (pick_valid) begin
                    grant_d = pick_id;
                    a_d     = pick_a;
                    b_d     = pick_b;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                cnt_d = cnt_q + CntW'(1);
                if (mult_done) begin
                    result_d = mult_result;
                    done_d   = OneHot0 << grant_q;
                    en_d     = 1'b0;
                    state_d  = StDone;
                end else if (TIMEOUT != 0 && cnt_q == CntLast) begin
                    err_d   = OneHot0 << grant_q;
                    en_d    = 1'b0;
                    state_d = StDone;
                end
            end
            StDone: begin
                ptr_d   = rr_next(grant_q, NUM_REQ);
                state_d = StIdle;
            end
            default: begin
                en_d    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            ptr_q    <= 3'd0;
            grant_q  <= 3'd0;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            en_q     <= 1'b0;
            done_q   <= '0;
            err_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            en_q     <= en_d;
            done_q   <= done_d;
            err_q    <= err_d;
            result_q <= result_d;
        end
    end

    assign resp_done   = done_q;
    assign resp_err    = err_q;
    assign resp_result = result_q;
    assign busy        = (state_q != StIdle);
    assign grant_id    = grant_q;
    assign mult_dataa  = a_q;
    assign mult_datab  = b_q;
    assign mult_enable = en_q;

endmodule

// File: doc/fp_mult_arbiter.md
Name: fp_mult_arbiter

Overview:
- Shares one floating-point multiplier (enable/done handshake, 32-bit IEEE-754 single-precision dataa/datab/result) among NUM_REQ requesters.
- Lets the function datapaths (0.5*x, x*x, scaling by 1/128, x^2*cos) reuse a single multiplier instance instead of one per product.
- Round-robin arbitration, operand latching and result return, plus a watchdog that aborts a multiply that never signals done.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, operand/result width (IEEE-754 single).
- TIMEOUT, 64, maximum BUSY cycles before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request level; held high with operands stable until that requester's resp_done or resp_err.
- req_dataa  in  NUM_REQ*DATA_W  packed operand A; slice i belongs to requester i.
- req_datab  in  NUM_REQ*DATA_W  packed operand B; slice i belongs to requester i.
- resp_done  out  NUM_REQ  one-hot, one-cycle pulse: result ready for that requester.
- resp_err  out  NUM_REQ  one-hot, one-cycle pulse: watchdog abort for that requester.
- resp_result  out  DATA_W  last completed product; holds until the next completion.
- busy  out  1  high in BUSY and DONE states.
- grant_id  out  3  index of the current or most recent grant.
- mult_dataa  out  DATA_W  latched operand A to the multiplier.
- mult_datab  out  DATA_W  latched operand B to the multiplier.
- mult_enable  out  1  multiplier start level; held high until done.
- mult_result  in  DATA_W  multiplier result.
- mult_done  in  1  multiplier done level.

Behaviour:
- Reset (async, reset_n=0): state IDLE; rr pointer 0; all outputs 0; grant_id 0; watchdog counter 0.
- States are IDLE, BUSY and DONE.
- IDLE:
  - If any req bit is set, pick the winner by round-robin: search starts at the rr pointer, wraps modulo NUM_REQ, lowest index first from there.
  - Latch the winner's operands into mult_dataa/mult_datab and set grant_id.
  - Clear the counter and go to BUSY. mult_enable rises on the same edge.
  - If no req bit is set, stay in IDLE.
  - mult_done seen in IDLE is stale and is ignored.
- BUSY:
  - mult_enable=1; operands held constant; counter increments each cycle.
  - If mult_done=1: capture mult_result into resp_result, go to DONE, and set a pending done for grant_id.
  - Else if TIMEOUT!=0 and counter==TIMEOUT-1: resp_result unchanged, go to DONE, and set a pending err for grant_id.
  - If done and the timeout coincide on the same cycle, done wins.
- DONE (exactly 1 cycle):
  - mult_enable=0.
  - resp_done[grant_id] or resp_err[grant_id] pulses high for this cycle only.
  - rr pointer <= (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
- Latency: request seen in IDLE at cycle t gives enable high from t+1. mult_done sampled at cycle k gives the response pulse at k+1. The next grant is issued at k+2 earliest, so enable is low for at least 1 cycle between operations and the multiplier re-arms.
- Requester drops req during BUSY: the operation is not aborted; its resp_done still pulses.
- req bits that rise during BUSY wait for the next IDLE arbitration.
- A requester holding req continuously cannot be granted twice in a row while another requester is pending.
- reset_n asserted mid-operation: immediate return to reset values, no response pulse; the multiplier sees enable fall.
- No arithmetic inside the block; operands and results pass through bit-exact.

Decomposition:
- Package fp_pkg:
  - DATA_W.
  - FP constants: FP_HALF 32'h3F000000, FP_ONE 32'h3F800000, FP_128 32'h43000000, FP_INV128 32'h3C000000.
  - State enum encoding (IDLE=0, BUSY=1, DONE=2).
- Sub-module rr_pick (combinational): inputs req and pointer; outputs valid and winner index.
- The FSM, operand mux/latch and watchdog stay in fp_mult_arbiter.

Test Plan:
- Single request: req=0001, a=0x3F000000, b=0x40000000, model done after 5 cycles → mult_enable high for 5 cycles; resp_done=0001 one cycle later; resp_result=0x3F800000; grant_id=0.
- Round-robin: req=1111 held, each op returns immediately → grant order 0,1,2,3,0; at least one enable-low cycle between consecutive grants.
- Pointer wrap: pointer=3 (after a grant to 2), req=0011 → requester 0 wins, then 1.
- Watchdog: TIMEOUT=8, model never asserts done → resp_err[grant_id] pulses exactly 8 cycles after enable rose; resp_result unchanged; next request serviced normally.
- Done and timeout same cycle: done on BUSY cycle TIMEOUT-1 → resp_done pulses, resp_err stays 0.
- Reset mid-BUSY: reset_n low at cycle 3 of BUSY → mult_enable, busy and resp_* go 0 immediately; no pulse after reset_n rises; stale mult_done high in IDLE is ignored.
